bram_wr_delay_line: RTL and testbench
=====================================

# bram_wr_delay_line

Parametrised write-back delay line for the BRAM write port of the DSP datapath. Carries a write enable, address and data word through a configurable number of register stages so the write lands in step with the arithmetic pipeline. Adds stall, flush, runtime latency selection and in-flight read-after-write hazard detection with data forwarding. Sits between the control unit's write-request outputs and the BRAM write port.

## Interface
- DEPTH, 5, number of physical stages; maximum latency (≥2)
- ADDR_WIDTH, 5, BRAM address width
- DATA_WIDTH, 16, write data width
- LW, $clog2(DEPTH)+1, width of lat_sel_i (derived, not overridden)
- CW, $clog2(DEPTH+1), width of occupancy_o (derived)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  hold all stages
- flush_i  in  1  invalidate all in-flight writes
- lat_sel_i  in  LW  requested latency, 1..DEPTH
- wr_en_i  in  1  write request
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  DATA_WIDTH  write data
- rd_addr_i  in  ADDR_WIDTH  address of concurrent BRAM read, for hazard check
- wr_en_o  out  1  delayed write enable to BRAM
- wr_addr_o  out  ADDR_WIDTH  delayed address
- wr_data_o  out  DATA_WIDTH  delayed data
- hazard_o  out  1  rd_addr_i matches an in-flight write
- fwd_data_o  out  DATA_WIDTH  data of youngest matching in-flight write
- occupancy_o  out  CW  count of valid entries in active stages

## Operation
- State: stages S[0..DEPTH-1], each {v, addr, data}; latency register lat_q.
- Active stages: S[0..lat_q-1]. Outputs read S[lat_q-1].
- lat_sel_i of 0 or >DEPTH is clamped to DEPTH.
- Priority each edge: reset > flush > stall > shift.
- Shift (no stall, no flush):
  - S[0] <= {wr_en_i, wr_addr_i, wr_data_i}; S[k] <= S[k-1].
  - v of every stage k ≥ lat_q is forced 0.
- Stall: all stages and lat_q hold; input is dropped. The upstream stage must not issue requests while stall_i=1.
- Flush: all v <= 0 (addr/data not required to clear). The input on the flush cycle is discarded. Flush overrides stall.
- Latency change: lat_q <= clamp(lat_sel_i) only on an edge where all active v=0, wr_en_i=0, stall_i=0 and flush_i=0. Otherwise the request stays pending (lat_q holds) and no in-flight write is lost or reordered.
- wr_en_o = S[lat_q-1].v & ~stall_i, so a held entry writes exactly once, on its first unstalled cycle.
- wr_addr_o / wr_data_o = S[lat_q-1].addr / .data, unconditionally.
- Hazard:
  - hazard_o = OR over k<lat_q of (S[k].v & S[k].addr==rd_addr_i).
  - fwd_data_o = data of the lowest-k (youngest) match; 0 when no match.
  - wr_en_i itself is not checked.
- occupancy_o = popcount of v over S[0..lat_q-1].

## Timing
- Reset: all v=0, addr=0, data=0, lat_q=DEPTH. Therefore wr_en_o=0, wr_addr_o=0, wr_data_o=0, hazard_o=0, fwd_data_o=0, occupancy_o=0.
- Reset mid-operation drops all in-flight writes immediately (asynchronous).
- Latency: a request sampled at edge t with no stalls drives wr_en_o=1 in the cycle after edge t+lat_q-1. For lat_q=1, it is visible one cycle after sampling.
- Each stall cycle adds exactly one cycle of latency to every in-flight entry.
- Outputs are combinational from registers plus stall_i (wr_en_o) and rd_addr_i (hazard_o, fwd_data_o); no extra register stage.
- Back-to-back requests every cycle sustain a throughput of one write per cycle.
- A latency change takes effect on the edge that updates lat_q; the next request then sees the new latency.

## Test plan
- Reset, DEPTH=5, lat_sel_i=5; write (addr 3, data 0x00AA) at edge 0 -> wr_en_o=1, wr_addr_o=3, wr_data_o=0x00AA in the cycle after edge 4 only; occupancy_o goes 1 then back to 0.
- Writes to addrs 1,2,3 on consecutive edges; stall_i high for 2 cycles while addr 1 is at S[4] -> wr_en_o=0 during the stall; addr 1 written once after release, then 2 and 3 on the following cycles.
- Three writes in flight, flush_i pulsed one cycle, with wr_en_i=1 on the same cycle -> occupancy_o=0 next cycle; wr_en_o stays 0 for the next 5 cycles.
- Writes to addr 7 with data 0x0011, then 0x0022 one cycle later; rd_addr_i=7 -> hazard_o=1, fwd_data_o=0x0022; rd_addr_i=8 -> hazard_o=0, fwd_data_o=0.
- lat_sel_i changed 5->2 with two writes in flight -> lat_q stays 5 until both drain, then becomes 2; the next write appears 2 cycles after sampling. lat_sel_i=0 -> clamped to 5.
- Reset asserted asynchronously mid-stream (between edges) -> all outputs 0 immediately; lat_q=5 after release.

Source files
------------

// File: rtl/bram_wr_delay_line.sv
// Write-back delay line for the BRAM write port: runtime-selectable latency,
// stall/flush control and read-after-write hazard forwarding from in-flight writes.
module bram_wr_delay_line #(
    parameter  int DEPTH      = 5,
    parameter  int ADDR_WIDTH = 5,
    parameter  int DATA_WIDTH = 16,
    localparam int LW         = $clog2(DEPTH) + 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [LW-1:0]         lat_sel_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  hazard_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic [CW-1:0]         occupancy_o
);

    logic [DEPTH-1:0]      v_q, v_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [LW-1:0]         lat_q, lat_d, lat_clamp_s;
    logic [DEPTH-1:0]      act_s;
    logic                  idle_s;
    logic                  out_v_s;

    // Out-of-range latency requests fall back to the full depth
    always_comb begin
        if ((lat_sel_i == '0) || (lat_sel_i > LW'(DEPTH))) begin
            lat_clamp_s = LW'(DEPTH);
        end else begin
            lat_clamp_s = lat_sel_i;
        end
    end

    // Mark stages inside the current latency window
    always_comb begin
        act_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            act_s[k] = (LW'(k) < lat_q);
        end
    end

    assign idle_s = ~|(v_q & act_s);

    // Next-state: flush beats stall beats shift; latency only moves when the window is empty
    always_comb begin
        v_d    = v_q;
        addr_d = addr_q;
        data_d = data_q;
        lat_d  = lat_q;
        if (flush_i) begin
            v_d = '0;
        end else if (stall_i) begin
            v_d = v_q;
        end else begin
            v_d[0]    = wr_en_i & act_s[0];
            addr_d[0] = wr_addr_i;
            data_d[0] = wr_data_i;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]    = v_q[k-1] & act_s[k];
                addr_d[k] = addr_q[k-1];
                data_d[k] = data_q[k-1];
            end
            lat_d = (idle_s && !wr_en_i) ? lat_clamp_s : lat_q;
        end
    end

    // Stage and latency registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q   <= '0;
            lat_q <= LW'(DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            lat_q  <= lat_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // Write port taps the last active stage; a stalled entry is withheld until released
    always_comb begin
        out_v_s   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            out_v_s   = (LW'(k) == (lat_q - LW'(1))) ? v_q[k]    : out_v_s;
            wr_addr_o = (LW'(k) == (lat_q - LW'(1))) ? addr_q[k] : wr_addr_o;
            wr_data_o = (LW'(k) == (lat_q - LW'(1))) ? data_q[k] : wr_data_o;
        end
        wr_en_o = out_v_s & ~stall_i;
    end

    // Hazard scan runs oldest to youngest so the youngest match wins the forward mux
    always_comb begin
        hazard_o    = 1'b0;
        fwd_data_o  = '0;
        occupancy_o = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hazard_o    = hazard_o | (act_s[k] & v_q[k] & (addr_q[k] == rd_addr_i));
            fwd_data_o  = (act_s[k] && v_q[k] && (addr_q[k] == rd_addr_i)) ? data_q[k] : fwd_data_o;
            occupancy_o = occupancy_o + CW'(act_s[k] & v_q[k]);
        end
    end

endmodule

// File: tb/tb_bram_wr_delay_line.sv
// Directed bench for bram_wr_delay_line: latency, stall, flush, hazard forwarding,
// latency reprogramming with clamping, and asynchronous reset.
module tb_bram_wr_delay_line;

    localparam int DEPTH = 5;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          stall_i;
    logic          flush_i;
    logic [LW-1:0] lat_sel_i;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic [AW-1:0] rd_addr_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          hazard_o;
    logic [DW-1:0] fwd_data_o;
    logic [CW-1:0] occupancy_o;

    int n_checks = 0;
    int n_errors = 0;

    bram_wr_delay_line #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .lat_sel_i(lat_sel_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .hazard_o(hazard_o),
        .fwd_data_o(fwd_data_o), .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; lat_sel_i = 4'd5;
        wr_en_i = 1'b0; wr_addr_i = 5'd0; wr_data_i = 16'h0000; rd_addr_i = 5'd0;
        #12;
        chk("rst_en",   32'(wr_en_o), 32'd0);
        chk("rst_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_data", 32'(wr_data_o), 32'd0);
        chk("rst_hz",   32'(hazard_o), 32'd0);
        chk("rst_fwd",  32'(fwd_data_o), 32'd0);
        chk("rst_occ",  32'(occupancy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_addr_i = 5'd31;

        // single write at full latency
        wr(5'd3, 16'h00AA);
        chk("t1_en_e0", 32'(wr_en_o), 32'd0);
        chk("t1_occ_e0", 32'(occupancy_o), 32'd1);
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("t1_en", 32'(wr_en_o), 32'(e == 4));
            chk("t1_occ", 32'(occupancy_o), (e <= 4) ? 32'd1 : 32'd0);
            if (e == 4) begin
                chk("t1_addr", 32'(wr_addr_o), 32'd3);
                chk("t1_data", 32'(wr_data_o), 32'h00AA);
            end
        end

        // stall while the oldest entry sits in the last stage
        wr(5'd1, 16'h0101);
        wr(5'd2, 16'h0102);
        wr(5'd3, 16'h0103);
        tick();
        tick();
        chk("t2_en_pre", 32'(wr_en_o), 32'd1);
        stall_i = 1'b1;
        #1;
        chk("t2_en_stall0", 32'(wr_en_o), 32'd0);
        tick();
        chk("t2_en_stall1", 32'(wr_en_o), 32'd0);
        chk("t2_occ_stall", 32'(occupancy_o), 32'd3);
        tick();
        chk("t2_en_stall2", 32'(wr_en_o), 32'd0);
        stall_i = 1'b0;
        #1;
        chk("t2_en_a1", 32'(wr_en_o), 32'd1);
        chk("t2_addr_a1", 32'(wr_addr_o), 32'd1);
        chk("t2_data_a1", 32'(wr_data_o), 32'h0101);
        tick();
        chk("t2_en_a2", 32'(wr_en_o), 32'd1);
        chk("t2_addr_a2", 32'(wr_addr_o), 32'd2);
        tick();
        chk("t2_en_a3", 32'(wr_en_o), 32'd1);
        chk("t2_addr_a3", 32'(wr_addr_o), 32'd3);
        tick();
        chk("t2_en_done", 32'(wr_en_o), 32'd0);
        chk("t2_occ_done", 32'(occupancy_o), 32'd0);

        // flush with a concurrent request
        wr(5'd4, 16'h0004);
        wr(5'd5, 16'h0005);
        wr(5'd6, 16'h0006);
        chk("t3_occ_pre", 32'(occupancy_o), 32'd3);
        flush_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 16'h0009;
        tick();
        flush_i = 1'b0; wr_en_i = 1'b0;
        chk("t3_occ", 32'(occupancy_o), 32'd0);
        rd_addr_i = 5'd9;
        #1;
        chk("t3_hz", 32'(hazard_o), 32'd0);
        rd_addr_i = 5'd31;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_en", 32'(wr_en_o), 32'd0);
        end

        // read-after-write hazard, youngest data forwarded
        wr(5'd7, 16'h0011);
        wr(5'd7, 16'h0022);
        rd_addr_i = 5'd7;
        #1;
        chk("t4_hz7", 32'(hazard_o), 32'd1);
        chk("t4_fwd7", 32'(fwd_data_o), 32'h0022);
        rd_addr_i = 5'd8;
        #1;
        chk("t4_hz8", 32'(hazard_o), 32'd0);
        chk("t4_fwd8", 32'(fwd_data_o), 32'd0);
        rd_addr_i = 5'd31;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_occ", 32'(occupancy_o), 32'd0);

        // latency change 5 -> 2 waits for in-flight writes to drain
        wr(5'd10, 16'h0A0A);
        lat_sel_i = 4'd2;
        wr(5'd11, 16'h0B0B);
        chk("t5_en_e1", 32'(wr_en_o), 32'd0);
        tick();
        chk("t5_en_e2", 32'(wr_en_o), 32'd0);
        tick();
        chk("t5_en_e3", 32'(wr_en_o), 32'd0);
        tick();
        chk("t5_en_e4", 32'(wr_en_o), 32'd1);
        chk("t5_addr_e4", 32'(wr_addr_o), 32'd10);
        tick();
        chk("t5_en_e5", 32'(wr_en_o), 32'd1);
        chk("t5_addr_e5", 32'(wr_addr_o), 32'd11);
        tick();
        chk("t5_en_e6", 32'(wr_en_o), 32'd0);
        tick();
        chk("t5_occ_e7", 32'(occupancy_o), 32'd0);
        wr(5'd12, 16'h0C0C);
        chk("t5_en_e8", 32'(wr_en_o), 32'd0);
        chk("t5_occ_e8", 32'(occupancy_o), 32'd1);
        tick();
        chk("t5_en_e9", 32'(wr_en_o), 32'd1);
        chk("t5_addr_e9", 32'(wr_addr_o), 32'd12);
        chk("t5_data_e9", 32'(wr_data_o), 32'h0C0C);
        tick();
        chk("t5_en_e10", 32'(wr_en_o), 32'd0);
        chk("t5_occ_e10", 32'(occupancy_o), 32'd0);

        // lat_sel 0 clamps to full depth
        lat_sel_i = 4'd0;
        tick();
        wr(5'd13, 16'h0D0D);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t5_clamp_en", 32'(wr_en_o), 32'(i == 4));
        end
        tick();
        chk("t5_clamp_done", 32'(wr_en_o), 32'd0);

        // asynchronous reset mid-stream
        lat_sel_i = 4'd2;
        tick();
        wr(5'd20, 16'h5555);
        wr(5'd21, 16'h6666);
        chk("t6_en_pre", 32'(wr_en_o), 32'd1);
        chk("t6_addr_pre", 32'(wr_addr_o), 32'd20);
        #2;
        rst_i = 1'b1;
        rd_addr_i = 5'd20;
        #1;
        chk("t6_en", 32'(wr_en_o), 32'd0);
        chk("t6_addr", 32'(wr_addr_o), 32'd0);
        chk("t6_data", 32'(wr_data_o), 32'd0);
        chk("t6_hz", 32'(hazard_o), 32'd0);
        chk("t6_fwd", 32'(fwd_data_o), 32'd0);
        chk("t6_occ", 32'(occupancy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_addr_i = 5'd31;
        wr(5'd22, 16'h7777);
        chk("t6_occ_post", 32'(occupancy_o), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t6_lat5_en", 32'(wr_en_o), 32'(i == 4));
            if (i == 4) chk("t6_lat5_addr", 32'(wr_addr_o), 32'd22);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
